uart_id_frame_rx: RTL and testbench
===================================

Name: uart_id_frame_rx

Overview:
Parametrised UART receiver that assembles a fixed number of serial bytes into one ID word for the gate/access controller.
- Adds over the current inline 40-bit receiver: input synchroniser, start-bit glitch rejection, stop-bit and optional parity checking, inter-byte gap timeout, and a valid/ready output handshake with overrun detection.
- Sits between the RS-232 RXD pin and the parking FSM, which consumes id_word.

Parameters:
CLKS_PER_BIT, 2604, clk cycles per serial bit (50 MHz / 19200 baud); must be ≥ 4.
DATA_BITS, 8, data bits per character, LSB first.
BYTES, 5, characters per ID word.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd (ignored if PARITY_EN = 0).
GAP_BITS, 20, idle bit-periods after which a partial word is discarded.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rxd  in  1  raw serial input, idle high
id_word  out  BYTES*DATA_BITS  assembled ID; first byte received occupies the LSBs
id_valid  out  1  id_word holds an unconsumed word
id_ready  in  1  consumer accepts id_word when id_valid && id_ready
frame_err  out  1  1-cycle pulse: stop bit sampled low
parity_err  out  1  1-cycle pulse: parity mismatch
overrun  out  1  1-cycle pulse: completed word dropped because output was still full
timeout  out  1  1-cycle pulse: partial word discarded on gap expiry
busy  out  1  character reception in progress (not IDLE)

Behaviour:
- Reset values: id_word = 0, id_valid = 0, all pulse outputs = 0, busy = 0, byte count = 0. Synchroniser flops reset to 1.
- rxd passes through a 2-FF synchroniser; all logic uses the synchronised signal rxs.
- Character FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: rxs = 0 → START, bit counter cleared.
- START: at count CLKS_PER_BIT/2 (integer division), resample rxs.
  - rxs = 1: glitch; return to IDLE with no flag.
  - rxs = 0: → DATA, counter cleared.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first. After DATA_BITS samples → PARITY if PARITY_EN, else → STOP.
- PARITY: sample one bit. Expected value = XOR of data bits, inverted if PARITY_ODD. Mismatch is latched; the flag is issued at STOP.
- STOP: sample once, then → IDLE on that sample.
  - Sample = 0: frame_err pulse; character discarded; partial word aborted (byte count = 0).
  - Sample = 1 with latched parity mismatch: parity_err pulse; same discard and abort.
  - Sample = 1, parity good: character written to slot byte_count; byte_count increments.
- Both frame and parity faulty: only frame_err pulses.
- Word completion: when byte_count reaches BYTES, the word is offered to the output register on the cycle after the stop sample, and byte_count returns to 0.
  - Output empty (id_valid = 0): id_word loads and id_valid = 1.
  - Output full with id_ready = 1 in the same cycle: old word is consumed, new word loads, id_valid stays 1, no overrun.
  - Output full with id_ready = 0: new word dropped, overrun pulses, id_word and id_valid unchanged.
- id_valid clears the cycle after id_valid && id_ready. id_word holds its value after consumption.
- Gap timer:
  - Runs only while IDLE with 0 < byte_count < BYTES.
  - Cleared on entering START.
  - Reaching GAP_BITS*CLKS_PER_BIT cycles: timeout pulse, byte_count = 0.
- Counter widths are derived with $clog2 from the parameters. No wrap is possible: every counter is cleared at its terminal value.
- Asserting reset mid-character or mid-word discards everything. After release, the receiver waits for a fresh falling edge; a line already low at release is treated as a start bit.

Decomposition:
- Package uart_rx_pkg: state enum, parity-compute function, width localparam helpers.
- Sub-module uart_char_rx: synchroniser, character FSM and error flags; outputs a char_valid/char_data strobe.
- Top level: byte assembly, gap timer and output handshake.

Test Plan (CLKS_PER_BIT = 16, GAP_BITS = 20 unless noted):
1. Send bytes 0x12, 0x34, 0x56, 0x78, 0x9A with id_ready = 1 → id_valid pulses one cycle with id_word = 0x9A78563412; no error pulses.
2. rxd low for 4 clks then high → busy rises then returns to 0; no character stored, no flags. Then one full 5-byte word → correct id_word.
3. Stop bit of byte 2 forced low → frame_err pulses once, no id_valid. Next 5 clean bytes 0x01..0x05 → id_word = 0x0504030201.
4. With id_ready = 0, send two full words back-to-back → first word held with id_valid = 1, overrun pulses at second completion. Raise id_ready → id_valid drops the next cycle.
5. PARITY_EN = 1, PARITY_ODD = 0: byte 0x01 with parity bit 0 → parity_err pulse and word aborted. Byte 0x01 with parity bit 1 → accepted.
6. Send 3 bytes, idle 320 clks → timeout pulse. Then 5 bytes 0xAA → id_word = 0xAAAAAAAAAA. Separately, reset asserted mid-byte → all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type and width/parity helpers for the ID-frame UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_char_rx.sv
// rtl/uart_char_rx.sv - synchronised single-character UART receiver with glitch, parity and stop checks
module uart_char_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 char_valid,
  output logic [DATA_BITS-1:0] char_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W = cnt_width(DATA_BITS);

  logic                 sync1, rxs;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bad, par_bad_n;
  logic                 char_valid_n, frame_err_n, parity_err_n;
  logic                 bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      par_bad    <= par_bad_n;
      char_valid <= char_valid_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
    end
  end

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_n        = bit_cnt;
    shift_n      = shift;
    par_bad_n    = par_bad;
    char_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        // Line back high at mid start bit means a glitch, not a character.
        if (cnt == CNT_W'(CLKS_PER_BIT / 2)) begin
          cnt_n     = '0;
          bit_n     = '0;
          par_bad_n = 1'b0;
          state_n   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {rxs, shift[DATA_BITS-1:1]};
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_n     = '0;
          par_bad_n = (rxs != calc_parity(32'(shift), PARITY_ODD != 0));
          state_n   = ST_STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (!rxs)         frame_err_n  = 1'b1;
          else if (par_bad) parity_err_n = 1'b1;
          else              char_valid_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign char_data = shift;
  assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/uart_id_frame_rx.sv
// rtl/uart_id_frame_rx.sv - assembles BYTES UART characters into one ID word with gap timeout and valid/ready output
module uart_id_frame_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_BITS    = 8,
  parameter int BYTES        = 5,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int GAP_BITS     = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rxd,
  output logic [BYTES*DATA_BITS-1:0] id_word,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  output logic                       timeout,
  output logic                       busy
);

  localparam int WORD_W     = BYTES * DATA_BITS;
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = cnt_width(GAP_CYCLES);
  localparam int BC_W       = cnt_width(BYTES + 1);

  logic                 char_valid;
  logic [DATA_BITS-1:0] char_data;
  logic [BC_W-1:0]      byte_count;
  logic [WORD_W-1:0]    word_acc;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 gap_run, gap_end, word_done;

  uart_char_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY_EN   (PARITY_EN),
    .PARITY_ODD  (PARITY_ODD)
  ) u_char (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .char_valid(char_valid),
    .char_data (char_data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  // The gap timer only matters for a partially collected word while the line is idle.
  assign gap_run   = !busy && (byte_count != '0) && (byte_count != BC_W'(BYTES));
  assign gap_end   = gap_run && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign word_done = (byte_count == BC_W'(BYTES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_count <= '0;
      word_acc   <= '0;
      gap_cnt    <= '0;
      id_word    <= '0;
      id_valid   <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (id_valid && id_ready) id_valid <= 1'b0;

      if (frame_err || parity_err) begin
        byte_count <= '0;
      end else if (char_valid) begin
        for (int i = 0; i < BYTES; i++)
          if (byte_count == BC_W'(i)) word_acc[i*DATA_BITS +: DATA_BITS] <= char_data;
        byte_count <= byte_count + BC_W'(1);
      end else if (word_done) begin
        byte_count <= '0;
        // A consumer taking the old word this cycle frees the register for the new one.
        if (!id_valid || id_ready) begin
          id_word  <= word_acc;
          id_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (gap_end) begin
        timeout    <= 1'b1;
        byte_count <= '0;
      end

      if (!gap_run || gap_end) gap_cnt <= '0;
      else                     gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_id_frame_rx.sv
// tb/tb_uart_id_frame_rx.sv - directed self-checking bench for uart_id_frame_rx (plain and even-parity instances)
module tb_uart_id_frame_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset, rxd, id_ready, rxd_p, id_ready_p;
  logic [39:0] id_word, id_word_p;
  logic        id_valid, frame_err, parity_err, overrun, timeout, busy;
  logic        id_valid_p, frame_err_p, parity_err_p, overrun_p, timeout_p, busy_p;

  always #5 clk = ~clk;

  uart_id_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(20)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .id_word(id_word), .id_valid(id_valid),
    .id_ready(id_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .timeout(timeout), .busy(busy)
  );

  uart_id_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(20), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .rxd(rxd_p), .id_word(id_word_p), .id_valid(id_valid_p),
    .id_ready(id_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .timeout(timeout_p), .busy(busy_p)
  );

  int n_tests = 0, n_fail = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, to_cnt = 0, acc_cnt = 0, vld_cyc = 0;
  int fe_p = 0, pe_p = 0, acc_p = 0;
  logic [39:0] last_word = '0, last_word_p = '0;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (timeout)    to_cnt++;
    if (id_valid)   vld_cyc++;
    if (id_valid && id_ready) begin acc_cnt++; last_word = id_word; end
    if (frame_err_p)  fe_p++;
    if (parity_err_p) pe_p++;
    if (id_valid_p && id_ready_p) begin acc_p++; last_word_p = id_word_p; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input bit par, input logic [7:0] data, input logic pbit, input logic stop_bit);
    logic [11:0] frame;
    int n;
    if (par) begin frame = {1'b1, stop_bit, pbit, data, 1'b0}; n = 12; end
    else     begin frame = {2'b11, stop_bit, data, 1'b0};      n = 11; end
    for (int i = 0; i < n; i++) begin
      if (par) rxd_p = frame[i];
      else     rxd   = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [39:0] w);
    for (int k = 0; k < 5; k++) send_char(1'b0, w[8*k +: 8], 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; rxd = 1'b1; rxd_p = 1'b1; id_ready = 1'b1; id_ready_p = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_word", id_word, 40'h0);
    check("rst_id_valid", id_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_err, parity_err, overrun, timeout}, 4'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    send_word(40'h9A78563412);
    check("t1_accepts", acc_cnt, 1);
    check("t1_word", last_word, 40'h9A78563412);
    check("t1_valid_cycles", vld_cyc, 1);
    check("t1_no_errs", fe_cnt + pe_cnt + ov_cnt + to_cnt, 0);

    rxd = 1'b0;
    repeat (4) @(posedge clk); #1;
    rxd = 1'b1;
    @(negedge clk);
    check("t2_busy_glitch", busy, 1);
    repeat (30) @(posedge clk); #1;
    check("t2_busy_back", busy, 0);
    check("t2_no_flags", fe_cnt + pe_cnt + to_cnt, 0);
    send_word(40'h5544332211);
    check("t2_accepts", acc_cnt, 2);
    check("t2_word", last_word, 40'h5544332211);

    send_char(1'b0, 8'h01, 1'b0, 1'b1);
    send_char(1'b0, 8'h02, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("t3_frame_err", fe_cnt, 1);
    check("t3_no_word", acc_cnt, 2);
    send_word(40'h0504030201);
    check("t3_accepts", acc_cnt, 3);
    check("t3_word", last_word, 40'h0504030201);
    check("t3_frame_once", fe_cnt, 1);

    id_ready = 1'b0;
    send_word(40'hA5A4A3A2A1);
    check("t4_valid_held", id_valid, 1);
    check("t4_word_held", id_word, 40'hA5A4A3A2A1);
    check("t4_no_overrun_yet", ov_cnt, 0);
    send_word(40'hB5B4B3B2B1);
    check("t4_overrun", ov_cnt, 1);
    check("t4_word_kept", id_word, 40'hA5A4A3A2A1);
    check("t4_valid_kept", id_valid, 1);
    id_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_at_ready", id_valid, 1);
    @(negedge clk);
    check("t4_valid_drop", id_valid, 0);
    check("t4_accepted_word", last_word, 40'hA5A4A3A2A1);
    @(posedge clk); #1;

    send_char(1'b1, 8'h10, 1'b1, 1'b1);
    send_char(1'b1, 8'h01, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("t5_parity_err", pe_p, 1);
    send_char(1'b1, 8'h01, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("t5_both_frame", fe_p, 1);
    check("t5_both_no_parity", pe_p, 1);
    send_char(1'b1, 8'h01, 1'b1, 1'b1);
    send_char(1'b1, 8'h03, 1'b0, 1'b1);
    send_char(1'b1, 8'h07, 1'b1, 1'b1);
    send_char(1'b1, 8'h0F, 1'b0, 1'b1);
    send_char(1'b1, 8'h80, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("t5_accepts", acc_p, 1);
    check("t5_word", last_word_p, 40'h800F070301);

    send_char(1'b0, 8'h11, 1'b0, 1'b1);
    send_char(1'b0, 8'h22, 1'b0, 1'b1);
    send_char(1'b0, 8'h33, 1'b0, 1'b1);
    repeat (280) @(posedge clk); #1;
    check("t6_no_early_timeout", to_cnt, 0);
    repeat (60) @(posedge clk); #1;
    check("t6_timeout", to_cnt, 1);
    send_word(40'hAAAAAAAAAA);
    check("t6_word", last_word, 40'hAAAAAAAAAA);
    check("t6_accepts", acc_cnt, 5);

    rxd = 1'b0; rxd_p = 1'b0;
    repeat (3 * CPB) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_id_word", id_word, 40'h0);
    check("t6_rst_id_word_p", id_word_p, 40'h0);
    check("t6_rst_valid", {id_valid, id_valid_p, busy_p}, 3'b0);
    check("t6_rst_pulses", {frame_err, parity_err, overrun, timeout}, 4'b0);
    rxd = 1'b1; rxd_p = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("t6_post_rst_idle", busy, 0);
    check("t6_post_rst_no_frame", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
